// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with mem_ready handshake.
// Optional perf counters (cycle/instr/stall) when MCCTRL_PERF_EN is defined.
module multicycle_ctrl
`ifdef MCCTRL_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OP,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  Mem2Reg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  EXTOp,
  output logic [2:0]  state,
  output logic        instr_done
`ifdef MCCTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_ORI  = 2'b10;

  state_t cur;
  state_t nxt;

  logic is_r;
  logic is_ori;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_jal;
  logic legal;

  // raw strobes, gated by reset before leaving the block
  logic pc_wr;
  logic mem_rd;
  logic mem_wr;
  logic ir_wr;
  logic reg_wr;
  logic done;

  // opcode class decode from the IR fields
  always_comb begin
    is_r   = (OP == OP_RTYPE);
    is_ori = (OP == OP_ORI);
    is_lw  = (OP == OP_LW);
    is_sw  = (OP == OP_SW);
    is_beq = (OP == OP_BEQ);
    is_jal = (OP == OP_JAL);
    legal  = is_r | is_ori | is_lw
           | is_sw | is_beq | is_jal;
  end

  // state register, reset aborts into FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // next-state and control decode per state
  always_comb begin
    nxt     = cur;
    pc_wr   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    done    = 1'b0;
    PCSrc   = 2'b00;
    IorD    = 1'b0;
    RegDst  = 2'b00;
    Mem2Reg = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOp   = ALU_ADDU;
    EXTOp   = 2'b00;
    unique case (cur)
      FETCH: begin
        mem_rd  = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = DECODE;
        end
      end
      DECODE: begin
        // branch target lands in ALUOut here
        ALUSrcB = 2'b11;
        EXTOp   = 2'b01;
        if (legal) begin
          nxt = EXEC;
        end else begin
          done = 1'b1;
          nxt  = FETCH;
        end
      end
      EXEC: begin
        unique case (1'b1)
          is_r: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b00;
            ALUOp   = (funct == FN_SUBU)
                    ? ALU_SUBU : ALU_ADDU;
            nxt     = WB;
          end
          is_ori: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = ALU_ORI;
            nxt     = WB;
          end
          is_lw, is_sw: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            EXTOp   = 2'b01;
            nxt     = MEM;
          end
          is_beq: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_SUBU;
            PCSrc   = 2'b01;
            pc_wr   = Zero;
            done    = 1'b1;
            nxt     = FETCH;
          end
          is_jal: begin
            // PC already holds PC+4 for the link
            PCSrc   = 2'b10;
            pc_wr   = 1'b1;
            reg_wr  = 1'b1;
            RegDst  = 2'b10;
            Mem2Reg = 2'b10;
            done    = 1'b1;
            nxt     = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        IorD = 1'b1;
        if (is_lw) begin
          mem_rd = 1'b1;
          if (mem_ready) nxt = WB;
        end else if (is_sw) begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            done = 1'b1;
            nxt  = FETCH;
          end
        end else begin
          nxt = FETCH;
        end
      end
      WB: begin
        reg_wr  = 1'b1;
        done    = 1'b1;
        RegDst  = is_r  ? 2'b01 : 2'b00;
        Mem2Reg = is_lw ? 2'b01 : 2'b00;
        nxt     = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  assign PCWrite    = pc_wr  & ~reset;
  assign MemRead    = mem_rd & ~reset;
  assign MemWrite   = mem_wr & ~reset;
  assign IRWrite    = ir_wr  & ~reset;
  assign RegWrite   = reg_wr & ~reset;
  assign instr_done = done   & ~reset;
  assign state      = cur;

`ifdef MCCTRL_PERF_EN
  logic stall;

  assign stall = ((cur == FETCH) || (cur == MEM))
               & ~mem_ready;

  // free-running perf counters, wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (instr_done)
        instr_cnt <= instr_cnt + PERF_W'(1);
      if (stall)
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction step lists with random stalls.
// Checks state, all controls and (if MCCTRL_PERF_EN) counters each cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP;
  logic [5:0] funct;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] Mem2Reg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] EXTOp;
  logic [2:0] state;
  logic       instr_done;
`ifdef MCCTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [31:0] stall_cnt;
`endif

  multicycle_ctrl dut (
    .clk(clk), .reset(reset),
    .OP(OP), .funct(funct),
    .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst),
    .Mem2Reg(Mem2Reg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .EXTOp(EXTOp), .state(state),
    .instr_done(instr_done)
`ifdef MCCTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {T_F, T_D, T_E, T_M, T_W} step_t;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] JAL = 6'b000011;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int m_cyc  = 0;
  int m_ins  = 0;
  int m_stl  = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit legal(logic [5:0] op);
    return op == RT || op == ORI || op == LW ||
           op == SW || op == BEQ || op == JAL;
  endfunction

  // instruction as a sequence of phases
  function automatic void plan(logic [5:0] op,
                               ref step_t q[$]);
    q = {};
    q.push_back(T_F);
    q.push_back(T_D);
    if (!legal(op)) return;
    q.push_back(T_E);
    if (op == LW || op == SW) q.push_back(T_M);
    if (op == RT || op == ORI || op == LW)
      q.push_back(T_W);
  endfunction

  // expected control word for one phase
  function automatic logic [19:0] exp_ctl(
      step_t s, logic [5:0] op, logic [5:0] fn,
      logic z, logic mr);
    logic pcw, iord, mrd, mwr, irw, rw, asa, dn;
    logic [1:0] pcs, rdst, m2r, asb, aop, ext;
    {pcw, iord, mrd, mwr, irw, rw, asa, dn} = '0;
    {pcs, rdst, m2r, asb, aop, ext} = '0;
    case (s)
      T_F: begin
        mrd = 1; asb = 2'b01; irw = mr; pcw = mr;
      end
      T_D: begin
        asb = 2'b11; ext = 2'b01; dn = !legal(op);
      end
      T_E: begin
        if (op == RT) begin
          asa = 1; aop = (fn == 6'b100011) ? 2'b01 : 2'b00;
        end else if (op == ORI) begin
          asa = 1; asb = 2'b10; aop = 2'b10;
        end else if (op == LW || op == SW) begin
          asa = 1; asb = 2'b10; ext = 2'b01;
        end else if (op == BEQ) begin
          asa = 1; aop = 2'b01; pcs = 2'b01;
          pcw = z; dn = 1;
        end else if (op == JAL) begin
          pcs = 2'b10; pcw = 1; rw = 1;
          rdst = 2'b10; m2r = 2'b10; dn = 1;
        end
      end
      T_M: begin
        iord = 1;
        if (op == LW) mrd = 1;
        else begin mwr = 1; dn = mr; end
      end
      T_W: begin
        rw = 1; dn = 1;
        rdst = (op == RT) ? 2'b01 : 2'b00;
        m2r  = (op == LW) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
    return {pcw, pcs, iord, mrd, mwr, irw, rw, rdst,
            m2r, asa, asb, aop, ext, dn};
  endfunction

  function automatic logic [19:0] obs_ctl();
    return {PCWrite, PCSrc, IorD, MemRead, MemWrite,
            IRWrite, RegWrite, RegDst, Mem2Reg,
            ALUSrcA, ALUSrcB, ALUOp, EXTOp, instr_done};
  endfunction

  task automatic chk_perf();
`ifdef MCCTRL_PERF_EN
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("instr_cnt", instr_cnt, m_ins);
    chk("stall_cnt", stall_cnt, m_stl);
`endif
  endtask

  task automatic do_cycle(step_t s, logic [5:0] op,
                          logic [5:0] fn, logic z,
                          logic mr);
    logic [19:0] e;
    OP = op; funct = fn; Zero = z; mem_ready = mr;
    @(negedge clk);
    e = exp_ctl(s, op, fn, z, mr);
    chk("state", 32'(state), 32'(s));
    chk("ctl", 32'(obs_ctl()), 32'(e));
    chk_perf();
    m_cyc++;
    if (e[0]) m_ins++;
    if ((s == T_F || s == T_M) && !mr) m_stl++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(logic [5:0] op,
                           logic [5:0] fn, logic zv,
                           int fst, int mst, bit rnd);
    step_t q[$];
    int i = 0;
    int fs = fst;
    int ms = mst;
    plan(op, q);
    while (i < q.size()) begin
      step_t s = q[i];
      logic mr = 1'b1;
      logic z = rnd ? logic'($urandom_range(0, 1)) : zv;
      bit   st = (s == T_F || s == T_M);
      if (rnd) begin
        mr = st ? ($urandom_range(0, 2) != 0)
                : logic'($urandom_range(0, 1));
      end else if (s == T_F && fs > 0) begin
        mr = 1'b0; fs--;
      end else if (s == T_M && ms > 0) begin
        mr = 1'b0; ms--;
      end
      do_cycle(s, op, fn, z, mr);
      if (!(st && !mr)) i++;
    end
  endtask

  initial begin
    logic [5:0] ops[7];
    ops = '{RT, ORI, LW, SW, BEQ, JAL, 6'b111111};
    reset = 1'b1; OP = '0; funct = '0;
    Zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'({PCWrite, IRWrite,
        RegWrite, MemWrite, MemRead, instr_done}), 0);
    chk_perf();
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(RT, 6'b100001, 0, 0, 0, 0);
    run_instr(RT, 6'b100011, 0, 1, 0, 0);
    run_instr(ORI, 6'b000000, 0, 0, 0, 0);
    run_instr(LW, 6'b000000, 0, 0, 2, 0);
    run_instr(SW, 6'b000000, 0, 2, 1, 0);
    run_instr(BEQ, 6'b000000, 1, 0, 0, 0);
    run_instr(BEQ, 6'b000000, 0, 0, 0, 0);
    run_instr(JAL, 6'b000000, 0, 0, 0, 0);
    run_instr(6'b111111, 6'b100001, 0, 0, 0, 0);
    run_instr(RT, 6'b000111, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      op = (n % 5 == 4) ? 6'($urandom)
                        : ops[$urandom_range(0, 6)];
      run_instr(op, 6'($urandom), 0, 0, 0, 1);
    end

    // abort a stalled store with reset
    do_cycle(T_F, SW, 0, 0, 1);
    do_cycle(T_D, SW, 0, 0, 1);
    do_cycle(T_E, SW, 0, 0, 1);
    OP = SW; mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_mem_wr", 32'(MemWrite), 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_memwr", 32'(MemWrite), 0);
    chk("abort_state", 32'(state), 0);
    m_cyc = 0; m_ins = 0; m_stl = 0;
    chk_perf();
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(RT, 6'b100001, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 6)],
                6'($urandom), 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle replacement for the single-cycle control unit.
- Sequences a shared-memory MIPS datapath (PC, IR, A/B, ALUOut, MDR registers) through FETCH/DECODE/EXEC/MEM/WB.
- Accepts a variable-latency memory via a mem_ready handshake.
- Supports the same instruction set: addu, subu, ori, lw, sw, beq, jal.

Parameters:
- PERF_W, 32, width of the performance counters; used only under MCCTRL_PERF_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- OP  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC load strobe
- PCSrc  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- IorD  out  1  memory address: 0 PC, 1 ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load strobe
- RegWrite  out  1  register file write
- RegDst  out  2  write register: 00 rt, 01 rd, 10 $31
- Mem2Reg  out  2  write data: 00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  1  ALU A: 0 PC, 1 A
- ALUSrcB  out  2  ALU B: 00 B, 01 constant 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  2  00 ADDU, 01 SUBU, 10 ORI
- EXTOp  out  2  00 zero-extend, 01 sign-extend
- state  out  3  current state, for debug
- instr_done  out  1  high during the final cycle of each instruction

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- State register reset value: FETCH.
- All outputs are combinational from state, OP, funct, Zero and mem_ready.
- Default value of every output not listed for a state is 0.
- While reset is high: PCWrite, IRWrite, RegWrite, MemWrite, MemRead and instr_done are forced to 0.
- Reset mid-instruction aborts it with no further writes; execution resumes in FETCH.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADDU, PCSrc=00.
  - mem_ready=1: IRWrite=1, PCWrite=1, next state DECODE.
  - mem_ready=0: stay in FETCH with IRWrite=0 and PCWrite=0.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, EXTOp=01, ALUOp=ADDU (branch target precomputed into ALUOut).
  - OP in {RTYPE 000000, ORI 001101, LW 100011, SW 101011, BEQ 000100, JAL 000011}: next state EXEC.
  - Any other OP: next state FETCH with instr_done=1 (treated as a NOP).
- EXEC:
  - RTYPE: ALUSrcA=1, ALUSrcB=00. ALUOp: funct 100001 gives ADDU, 100011 gives SUBU, any other funct gives ADDU. Next state WB.
  - ORI: ALUSrcA=1, ALUSrcB=10, EXTOp=00, ALUOp=ORI. Next state WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=10, EXTOp=01, ALUOp=ADDU. Next state MEM.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=SUBU, PCSrc=01, PCWrite=Zero, instr_done=1. Next state FETCH.
  - JAL: PCSrc=10, PCWrite=1, RegWrite=1, RegDst=10, Mem2Reg=10 (PC already holds PC+4), instr_done=1. Next state FETCH.
- MEM (IorD=1):
  - LW: MemRead=1; on mem_ready go to WB, otherwise hold.
  - SW: MemWrite=1 held until mem_ready; on mem_ready, instr_done=1 and go to FETCH.
  - The memory must treat a held MemWrite as a single write.
- WB:
  - RegWrite=1, instr_done=1, next state FETCH.
  - RTYPE: RegDst=01, Mem2Reg=00. ORI: RegDst=00, Mem2Reg=00. LW: RegDst=00, Mem2Reg=01.
- Latency with mem_ready held at 1:
  - beq, jal: 3 cycles.
  - R-type, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - Illegal OP: 2 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.

Optional Feature:
- Macro: MCCTRL_PERF_EN.
- When defined, adds three outputs, each reset to 0 and wrapping modulo 2^PERF_W:
  - cycle_cnt  out  PERF_W: counts every clock cycle out of reset.
  - instr_cnt  out  PERF_W: increments on every cycle with instr_done=1.
  - stall_cnt  out  PERF_W: increments on every FETCH or MEM cycle with mem_ready=0.
- When undefined, these ports and counters do not exist and the behaviour above is unchanged.

Test Plan:
- Reset then release, mem_ready=1, IR=addu (OP=000000, funct=100001) -> states 0,1,2,4; IRWrite and PCWrite in cycle 1; RegWrite=1 with RegDst=01 in cycle 4; instr_done pulses once.
- lw (100011) with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with MemRead=1 and IorD=1; then WB with Mem2Reg=01; total 7 cycles.
- beq (000100): Zero=1 -> EXEC has PCWrite=1, PCSrc=01. Zero=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
- jal (000011) -> EXEC asserts PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, Mem2Reg=10.
- Illegal OP 111111 -> DECODE goes to FETCH; no RegWrite or MemWrite ever asserted.
- reset asserted mid-MEM of sw -> MemWrite drops immediately; state=0 after release; under MCCTRL_PERF_EN all counters read 0.
